avalon_sample_fifo: RTL and testbench
=====================================

Name: avalon_sample_fifo

Overview:
- Avalon-MM slave front end that sits directly upstream of the CORDIC accumulate core.
- Accepts float32 samples from the Nios bus and buffers them in a FIFO.
- Streams the samples to the core over a valid/ready interface.
- Returns the core's accumulated result and status to software, stalling the bus with waitrequest when it must.

Parameters:
- DEPTH, 16, FIFO entries (power of two, at least 2)
- DATA_W, 32, sample/result width (IEEE-754 single)
- CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- address  in  1  0 = data/result, 1 = control/status
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- waitrequest  out  1  Avalon stall
- readdatavalid  out  1  high for one cycle when readdata is valid
- out_valid  out  1  sample available to core
- out_ready  in  1  core accepts sample
- out_data  out  DATA_W  sample to core
- acc_clear  out  1  one-cycle pulse that clears the core accumulator
- core_busy  in  1  core has samples in flight
- res_data  in  DATA_W  core accumulated result

Behaviour:
- Reset (reset_n sampled low at a clk edge): FIFO empty, count = 0, rd/wr pointers = 0. readdata = 0, readdatavalid = 0, acc_clear = 0, out_valid = 0. waitrequest is combinational, so it reads 0 while the FIFO is empty and idle.
- Write, address 0 (push):
  - FIFO not full: writedata is stored at wr_ptr, wr_ptr increments, waitrequest = 0.
  - FIFO full: waitrequest = 1 and nothing is stored; the master holds the request until a slot frees.
- Write, address 1 (control): any value flushes the FIFO (pointers and count to 0) and asserts acc_clear for exactly the next cycle. writedata[31:0] is ignored in this revision. waitrequest = 0.
- Stream side:
  - out_valid = (count != 0); out_data = mem[rd_ptr], available combinationally from the head.
  - A pop occurs when out_valid && out_ready; rd_ptr increments.
- Simultaneous push and pop in one cycle: count is unchanged, and a push to a full FIFO is still refused in that cycle.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Read, address 0 (result):
  - waitrequest = 1 while count != 0, core_busy = 1, or acc_clear = 1.
  - Once drained, waitrequest = 0, res_data is latched into readdata, and readdatavalid = 1 on the following cycle (1-cycle read latency).
- Read, address 1 (status): never stalls.
  - readdata = {16'b0, count zero-extended to 8 bits, 4'b0, core_busy, full, empty, result_ready}.
  - result_ready = empty && !core_busy.
  - Same 1-cycle latency as address 0.
- read and write asserted together: write takes priority and the read is ignored.
- Flush in the same cycle as a pop or push: the flush wins and both are dropped.
- Reset mid-transfer: everything returns to its reset state on that edge, and any pending stall is released.

Optional Feature:
- Macro: SAMPLE_CHECK_EN.
- Defined:
  - An address-0 write whose exponent field is all ones (NaN/Inf) is accepted with waitrequest = 0 but is not pushed.
  - An 8-bit saturating drop counter increments on each such write and is cleared by a control write or reset.
  - The counter appears in status bits [31:24].
- Undefined: all values are pushed unchanged, and status bits [31:24] read 0.

Decomposition:
- Shared package cordic_bus_pkg holds:
  - ADDR_DATA = 1'b0, ADDR_CTRL = 1'b1;
  - status bit-position constants;
  - FP_EXP_MSB/LSB = 30/23.
- One natural sub-module, sync_fifo: parameterised DEPTH/DATA_W, with push/pop/flush inputs and full/empty/count outputs. The Avalon decode, stall logic and read mux stay in the top of this block.

Test Plan:
- Reset then read address 1: readdatavalid after 1 cycle with readdata = 0x00000003 (empty = 1, result_ready = 1).
- Write address 1 = 0, then address 0 = 0x437f0000 with out_ready = 1: acc_clear pulses for 1 cycle; out_valid for 1 cycle with out_data = 0x437f0000; count returns to 0.
- out_ready = 0, then 17 writes to address 0: waitrequest = 0 for the first 16 and 1 on the 17th. Raising out_ready for 1 cycle completes the 17th write, and count stays 16.
- Write 0x43000000, 0x42080000 and 0x42be0000, then read address 0 with core_busy = 1 for 5 cycles and res_data = 0x45a00000: waitrequest stays high until the FIFO is empty and core_busy is low; readdata = 0x45a00000 one cycle later.
- Control write in the same cycle as a pop while count = 3: count goes to 0, out_valid = 0, and acc_clear = 1 next cycle.
- With SAMPLE_CHECK_EN, write 0x7fc00000 and then 0x42800000: only 0x42800000 appears on out_data, and status[31:24] = 1.

Source files
------------

// File: rtl/cordic_bus_pkg.sv
// Shared register-map constants and sample helpers for the Nios-facing CORDIC accumulate front end.
package cordic_bus_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int STAT_RESULT_READY = 0;
  localparam int STAT_EMPTY        = 1;
  localparam int STAT_FULL         = 2;
  localparam int STAT_CORE_BUSY    = 3;
  localparam int STAT_COUNT_LSB    = 8;
  localparam int STAT_DROP_LSB     = 24;

  localparam int FP_EXP_MSB = 30;
  localparam int FP_EXP_LSB = 23;

  // All-ones exponent marks NaN or +/-Inf in IEEE-754 single precision.
  function automatic logic is_nonfinite(input logic [31:0] value);
    return &value[FP_EXP_MSB:FP_EXP_LSB];
  endfunction

endpackage

// File: rtl/avalon_sample_fifo_sync_fifo.sv
// Synchronous FIFO with flush; head word is visible combinationally.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  // Full is judged on the current count, so a pop in the same cycle does not make room.
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/avalon_sample_fifo.sv
// Avalon-MM slave buffering float32 samples for the CORDIC accumulate core and returning its result.
// Optional SAMPLE_CHECK_EN: drop non-finite samples and count them in status[31:24].
module avalon_sample_fifo
  import cordic_bus_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              address,
  input  logic              write,
  input  logic              read,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic              readdatavalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              acc_clear,
  input  logic              core_busy,
  input  logic [DATA_W-1:0] res_data
);

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             ctrl_wr;
  logic             data_wr;
  logic             rd_req;
  logic             sample_ok;
  logic             wr_stall;
  logic             rd_stall;
  logic             rd_accept;
  logic [7:0]       drop_cnt;
  logic [7:0]       count8;
  logic [31:0]      status;

  // A write always wins over a simultaneous read.
  assign ctrl_wr = write && (address == ADDR_CTRL);
  assign data_wr = write && (address == ADDR_DATA);
  assign rd_req  = read && !write;

`ifdef SAMPLE_CHECK_EN
  logic bad_sample;

  // Rejected samples never occupy a slot, so they are never stalled either.
  assign bad_sample = data_wr && is_nonfinite(writedata);
  assign sample_ok  = !bad_sample;

  always_ff @(posedge clk) begin
    if (!reset_n || ctrl_wr) begin
      drop_cnt <= '0;
    end else if (bad_sample && (drop_cnt != 8'hff)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign sample_ok = 1'b1;
  assign drop_cnt  = '0;
`endif

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (data_wr && sample_ok),
    .push_data (writedata[DATA_W-1:0]),
    .pop       (out_ready),
    .flush     (ctrl_wr),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;

  // The result is only meaningful once every sample has left the FIFO and the core.
  assign wr_stall    = data_wr && sample_ok && fifo_full;
  assign rd_stall    = rd_req && (address == ADDR_DATA) &&
                       (!fifo_empty || core_busy || acc_clear);
  assign waitrequest = wr_stall || rd_stall;
  assign rd_accept   = rd_req && !rd_stall;

  assign count8 = 8'(fifo_count);

  always_comb begin
    status                              = '0;
    status[STAT_RESULT_READY]           = fifo_empty && !core_busy;
    status[STAT_EMPTY]                  = fifo_empty;
    status[STAT_FULL]                   = fifo_full;
    status[STAT_CORE_BUSY]              = core_busy;
    status[STAT_COUNT_LSB +: 8]         = count8;
    status[STAT_DROP_LSB +: 8]          = drop_cnt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      acc_clear     <= 1'b0;
    end else begin
      acc_clear     <= ctrl_wr;
      readdatavalid <= rd_accept;
      if (rd_accept) begin
        readdata <= (address == ADDR_DATA) ? 32'(res_data) : status;
      end
    end
  end

endmodule

// File: tb/tb_avalon_sample_fifo.sv
// Scoreboard bench for avalon_sample_fifo: queue-based reference model, directed scenarios plus random traffic.
module tb_avalon_sample_fifo;

  localparam int DEPTH  = 16;
  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        address = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        readdatavalid;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        acc_clear;
  logic        core_busy = 1'b0;
  logic [31:0] res_data = '0;

  always #5 clk = ~clk;

  avalon_sample_fifo #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .write         (write),
    .read          (read),
    .writedata     (writedata),
    .readdata      (readdata),
    .waitrequest   (waitrequest),
    .readdatavalid (readdatavalid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .acc_clear     (acc_clear),
    .core_busy     (core_busy),
    .res_data      (res_data)
  );

  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  bit          done = 1'b0;
  logic [31:0] q[$];
  logic [31:0] rd_exp[$];
  bit          clr_pend = 1'b0;
  int          drop_cnt = 0;

  function automatic bit nonfinite(input logic [31:0] d);
    return d[30:23] == 8'hff;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs checked against the model, then the model advances by one clock.
  always @(negedge clk) begin
    if (mon_en) begin
      bit          empty_m, full_m, ctrl, dwr, bad, pred_wr, pred_rd;
      logic [31:0] st;
      logic [31:0] exp_rd;
      empty_m = (q.size() == 0);
      full_m  = (q.size() == DEPTH);

      check1("out_valid", out_valid, !empty_m);
      if (!empty_m) check("out_data", out_data, q[0]);
      check1("acc_clear", acc_clear, clr_pend);
      if (rd_exp.size() != 0) begin
        exp_rd = rd_exp.pop_front();
        check1("readdatavalid", readdatavalid, 1'b1);
        if (readdatavalid) check("readdata", readdata, exp_rd);
      end else begin
        check1("readdatavalid_idle", readdatavalid, 1'b0);
      end

      ctrl = write && address;
      dwr  = write && !address;
      bad  = 1'b0;
`ifdef SAMPLE_CHECK_EN
      bad = dwr && nonfinite(writedata);
`endif
      pred_wr = dwr && !bad && full_m;
      pred_rd = read && !write && !address && (!empty_m || core_busy || clr_pend);
      check1("waitrequest", waitrequest, pred_wr || pred_rd);

      if (!reset_n) begin
        q.delete();
        clr_pend = 1'b0;
        drop_cnt = 0;
      end else begin
        if (read && !write && !pred_rd) begin
          if (!address) begin
            rd_exp.push_back(res_data);
          end else begin
            st        = '0;
            st[31:24] = drop_cnt[7:0];
            st[15:8]  = 8'(q.size());
            st[3]     = core_busy;
            st[2]     = full_m;
            st[1]     = empty_m;
            st[0]     = empty_m && !core_busy;
            rd_exp.push_back(st);
          end
        end
        clr_pend = ctrl;
        if (ctrl) begin
          q.delete();
          drop_cnt = 0;
        end else begin
          if (!empty_m && out_ready) void'(q.pop_front());
          if (dwr && bad) begin
            if (drop_cnt < 255) drop_cnt++;
          end else if (dwr && !full_m) begin
            q.push_back(writedata);
          end
        end
      end
    end
  end

  task automatic bus_write(input logic a, input logic [31:0] d, output int stalls);
    write = 1'b1; address = a; writedata = d; stalls = 0;
    forever begin
      @(negedge clk);
      if (!waitrequest) break;
      stalls++;
      if (stalls > BUDGET) begin
        checks++; errors++;
        $display("FAIL bus_write_timeout: still stalled after %0d cycles, required release", stalls);
        break;
      end
    end
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic bus_read(input logic a, output int stalls);
    read = 1'b1; address = a; stalls = 0;
    forever begin
      @(negedge clk);
      if (!waitrequest) break;
      stalls++;
      if (stalls > BUDGET) begin
        checks++; errors++;
        $display("FAIL bus_read_timeout: still stalled after %0d cycles, required release", stalls);
        break;
      end
    end
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    int s17;
    int rd_stalls;

    @(posedge clk); #1;
    mon_en = 1'b1;
    idle(2);
    reset_n = 1'b1;
    idle(1);

    // Status straight after reset: empty and result_ready.
    bus_read(1'b1, s);
    idle(1);

    // Flush then one sample through to the core.
    bus_write(1'b1, 32'h0, s);
    out_ready = 1'b1;
    bus_write(1'b0, 32'h437f0000, s);
    idle(3);

    // Fill to 16, 17th write stalls until one slot frees.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus_write(1'b0, 32'h3f800000 + 32'(i), s);
      check("fill_no_stall", 32'(s), 32'd0);
    end
    fork
      bus_write(1'b0, 32'h40000000, s17);
      begin
        idle(3);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
      end
    join
    check1("write17_stalled", s17 != 0, 1'b1);
    bus_read(1'b1, s);
    idle(1);

    // Result read waits for drain and core idle.
    bus_write(1'b1, 32'h0, s);
    bus_write(1'b0, 32'h43000000, s);
    bus_write(1'b0, 32'h42080000, s);
    bus_write(1'b0, 32'h42be0000, s);
    res_data = 32'h45a00000;
    fork
      bus_read(1'b0, rd_stalls);
      begin
        core_busy = 1'b1;
        out_ready = 1'b1;
        idle(5);
        core_busy = 1'b0;
      end
    join
    check("result_stall_cycles", 32'(rd_stalls), 32'd5);
    idle(2);

    // Flush collides with a pop at count 3.
    out_ready = 1'b0;
    bus_write(1'b0, 32'h11111111, s);
    bus_write(1'b0, 32'h22222222, s);
    bus_write(1'b0, 32'h33333333, s);
    out_ready = 1'b1;
    bus_write(1'b1, 32'h0, s);
    out_ready = 1'b0;
    bus_read(1'b1, s);
    idle(2);

`ifdef SAMPLE_CHECK_EN
    bus_write(1'b0, 32'h7fc00000, s);
    bus_write(1'b0, 32'h42800000, s);
    bus_read(1'b1, s);
    out_ready = 1'b1;
    idle(2);
    out_ready = 1'b0;
`endif

    // Reset while a write is stalled on a full FIFO.
    bus_write(1'b1, 32'h0, s);
    for (int i = 0; i < 16; i++) bus_write(1'b0, 32'h40400000 + 32'(i), s);
    fork
      bus_write(1'b0, 32'h40a00000, s);
      begin
        idle(2);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
      end
    join
    bus_read(1'b1, s);
    idle(2);

    // Random traffic.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          int          r;
          logic [31:0] d;
          r = int'($urandom_range(11));
          if (r <= 4) begin
            d = $urandom;
            if ($urandom_range(7) == 0) d[30:23] = 8'hff;
            bus_write(1'b0, d, s);
          end else if (r == 5) begin
            bus_write(1'b1, $urandom, s);
          end else if (r <= 7) begin
            bus_read(1'b0, s);
          end else if (r <= 9) begin
            bus_read(1'b1, s);
          end else begin
            idle(1);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(1));
          core_busy = ($urandom_range(3) == 0);
          res_data  = $urandom;
        end
      end
    join

    core_busy = 1'b0;
    out_ready = 1'b1;
    idle(DEPTH + 4);
    check1("no_pending_reads", rd_exp.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
